// File: rtl/ef_qspi_xip_arb.sv
// Two-requester AHB-Lite read arbiter in front of a shared QSPI XIP controller.
// Reads are posted as pending requests and serviced one at a time with round-robin on ties.
module ef_qspi_xip_arb #(
  parameter int AW = 24
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL_0,
  input  logic [1:0]    HTRANS_0,
  input  logic [AW-1:0] HADDR_0,
  input  logic          HWRITE_0,
  input  logic          HREADY_0,
  output logic          HREADYOUT_0,
  output logic [31:0]   HRDATA_0,
  input  logic          HSEL_1,
  input  logic [1:0]    HTRANS_1,
  input  logic [AW-1:0] HADDR_1,
  input  logic          HWRITE_1,
  input  logic          HREADY_1,
  output logic          HREADYOUT_1,
  output logic [31:0]   HRDATA_1,
  output logic          S_HSEL,
  output logic [1:0]    S_HTRANS,
  output logic [AW-1:0] S_HADDR,
  output logic          S_HREADY,
  input  logic          S_HREADYOUT,
  input  logic [31:0]   S_HRDATA,
  output logic [1:0]    GNT
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e               state_q;
  logic [1:0]           pend_q;
  logic [1:0][AW-1:0]   addr_q;
  logic [1:0][31:0]     rdata_q;
  logic                 own_q;
  logic                 last_q;
  logic [1:0]           gnt_q;
  logic                 s_hsel_q;
  logic [1:0]           s_htrans_q;
  logic [AW-1:0]        s_haddr_q;

  logic [1:0]           acc;
  logic [1:0]           clr;
  logic [1:0][AW-1:0]   haddr;
  logic                 pick;

  // Only reads are queued; writes complete immediately and are dropped.
  assign acc[0] = HREADY_0 & HSEL_0 & (HTRANS_0 == 2'b10 || HTRANS_0 == 2'b11) & ~HWRITE_0;
  assign acc[1] = HREADY_1 & HSEL_1 & (HTRANS_1 == 2'b10 || HTRANS_1 == 2'b11) & ~HWRITE_1;
  assign haddr[0] = HADDR_0;
  assign haddr[1] = HADDR_1;

  assign clr  = (state_q == WAIT && S_HREADYOUT) ? gnt_q : 2'b00;
  // Tie goes to whoever was not served last.
  assign pick = (&pend_q) ? ~last_q : pend_q[1];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= IDLE;
      pend_q     <= 2'b00;
      addr_q     <= '0;
      rdata_q    <= '0;
      own_q      <= 1'b0;
      last_q     <= 1'b1;
      gnt_q      <= 2'b00;
      s_hsel_q   <= 1'b0;
      s_htrans_q <= 2'b00;
      s_haddr_q  <= '0;
    end else begin
      pend_q <= (pend_q & ~clr) | acc;
      for (int i = 0; i < 2; i++)
        if (acc[i]) addr_q[i] <= haddr[i];
      unique case (state_q)
        IDLE: if (|pend_q) begin
          own_q      <= pick;
          gnt_q      <= pick ? 2'b10 : 2'b01;
          s_hsel_q   <= 1'b1;
          s_htrans_q <= 2'b10;
          s_haddr_q  <= addr_q[pick];
          state_q    <= ISSUE;
        end
        ISSUE: if (S_HREADYOUT) begin
          s_hsel_q   <= 1'b0;
          s_htrans_q <= 2'b00;
          state_q    <= WAIT;
        end
        WAIT: if (S_HREADYOUT) begin
          rdata_q[own_q] <= S_HRDATA;
          last_q         <= own_q;
          gnt_q          <= 2'b00;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign HREADYOUT_0 = ~pend_q[0];
  assign HREADYOUT_1 = ~pend_q[1];
  assign HRDATA_0    = rdata_q[0];
  assign HRDATA_1    = rdata_q[1];
  assign S_HSEL      = s_hsel_q;
  assign S_HTRANS    = s_htrans_q;
  assign S_HADDR     = s_haddr_q;
  assign S_HREADY    = S_HREADYOUT;
  assign GNT         = gnt_q;

endmodule

// File: tb/tb_ef_qspi_xip_arb.sv
// Bench for ef_qspi_xip_arb: flash slave model with programmable waits, a transaction-level
// expectation model checked every cycle, and directed scenarios with literal expectations.
module tb_ef_qspi_xip_arb;
  localparam int AW = 24;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          HSEL_0, HWRITE_0, HREADY_0, HREADYOUT_0;
  logic [1:0]    HTRANS_0;
  logic [AW-1:0] HADDR_0;
  logic [31:0]   HRDATA_0;
  logic          HSEL_1, HWRITE_1, HREADY_1, HREADYOUT_1;
  logic [1:0]    HTRANS_1;
  logic [AW-1:0] HADDR_1;
  logic [31:0]   HRDATA_1;
  logic          S_HSEL, S_HREADY, S_HREADYOUT;
  logic [1:0]    S_HTRANS, GNT;
  logic [AW-1:0] S_HADDR;
  logic [31:0]   S_HRDATA;

  ef_qspi_xip_arb #(.AW(AW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .HSEL_0(HSEL_0), .HTRANS_0(HTRANS_0), .HADDR_0(HADDR_0), .HWRITE_0(HWRITE_0),
    .HREADY_0(HREADY_0), .HREADYOUT_0(HREADYOUT_0), .HRDATA_0(HRDATA_0),
    .HSEL_1(HSEL_1), .HTRANS_1(HTRANS_1), .HADDR_1(HADDR_1), .HWRITE_1(HWRITE_1),
    .HREADY_1(HREADY_1), .HREADYOUT_1(HREADYOUT_1), .HRDATA_1(HRDATA_1),
    .S_HSEL(S_HSEL), .S_HTRANS(S_HTRANS), .S_HADDR(S_HADDR), .S_HREADY(S_HREADY),
    .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA), .GNT(GNT)
  );

  always #5 HCLK = ~HCLK;

  // Each requester sits alone on its bus, so its HREADY is its own HREADYOUT.
  assign HREADY_0 = HREADYOUT_0;
  assign HREADY_1 = HREADYOUT_1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word(input logic [AW-1:0] a);
    return {a[7:0] + 8'd3, a[7:0] + 8'd2, a[7:0] + 8'd1, a[7:0]};
  endfunction

  // Flash slave: byte i at address i, slv_waits wait cycles per data phase.
  int          slv_waits = 0;
  logic        dp_act;
  int          dp_cnt;
  logic [AW-1:0] dp_addr;
  assign S_HREADYOUT = !dp_act || dp_cnt == 0;
  assign S_HRDATA    = (dp_act && dp_cnt == 0) ? word(dp_addr) : 32'hDEADBEEF;

  // Expectation model: outstanding reads, their addresses, delivered data, issue log.
  logic [1:0]    m_out;
  logic [AW-1:0] m_addr [2];
  logic [31:0]   m_rdata [2];
  int            glog[$];

  always @(posedge HCLK) begin
    if (HRESET) begin
      m_out      <= 2'b00;
      m_rdata[0] <= '0;
      m_rdata[1] <= '0;
      dp_act     <= 1'b0;
      dp_cnt     <= 0;
    end else begin
      if (dp_act && dp_cnt != 0) dp_cnt <= dp_cnt - 1;
      else begin
        if (dp_act) begin
          m_out[GNT[1]]   <= 1'b0;
          m_rdata[GNT[1]] <= word(m_addr[GNT[1]]);
        end
        if (S_HSEL && S_HTRANS[1]) begin
          dp_act  <= 1'b1;
          dp_addr <= S_HADDR;
          dp_cnt  <= slv_waits;
          glog.push_back(int'(GNT[1]));
        end else dp_act <= 1'b0;
      end
      if (HREADY_0 && HSEL_0 && HTRANS_0[1] && !HWRITE_0) begin m_out[0] <= 1'b1; m_addr[0] <= HADDR_0; end
      if (HREADY_1 && HSEL_1 && HTRANS_1[1] && !HWRITE_1) begin m_out[1] <= 1'b1; m_addr[1] <= HADDR_1; end
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge HCLK);
    if (chk_en) begin
      chk("s_hready", S_HREADY, S_HREADYOUT);
      chk("hreadyout0", HREADYOUT_0, !m_out[0]);
      chk("hreadyout1", HREADYOUT_1, !m_out[1]);
      chk("hrdata0", HRDATA_0, m_rdata[0]);
      chk("hrdata1", HRDATA_1, m_rdata[1]);
      chk("gnt_legal", GNT != 2'b11, 1);
      if (S_HSEL) begin
        chk("s_htrans_issue", S_HTRANS, 2'b10);
        chk("s_gnt_set", GNT != 2'b00, 1);
        chk("s_haddr", S_HADDR, m_addr[GNT[1]]);
        chk("s_owner_pend", m_out[GNT[1]], 1);
      end else chk("s_htrans_idle", S_HTRANS, 2'b00);
    end
  end

  task automatic setreq(input int x, input logic s, input logic [1:0] t, input logic [AW-1:0] a, input logic w);
    if (x == 0) begin HSEL_0 = s; HTRANS_0 = t; HADDR_0 = a; HWRITE_0 = w; end
    else        begin HSEL_1 = s; HTRANS_1 = t; HADDR_1 = a; HWRITE_1 = w; end
  endtask

  function automatic logic rdy(input int x);
    return (x == 0) ? HREADYOUT_0 : HREADYOUT_1;
  endfunction

  function automatic logic [31:0] rdat(input int x);
    return (x == 0) ? HRDATA_0 : HRDATA_1;
  endfunction

  // Single read; lat counts cycles from the address phase until HREADYOUT returns.
  task automatic rd(input int x, input logic [AW-1:0] a, output int lat, output logic [1:0] gs);
    @(negedge HCLK);
    setreq(x, 1'b1, 2'b10, a, 1'b0);
    gs = 2'b00; lat = 0;
    do begin
      @(negedge HCLK);
      setreq(x, 1'b0, 2'b00, '0, 1'b0);
      lat++;
      gs |= GNT;
    end while (!rdy(x) && lat < 60);
    if (!rdy(x)) chk("rd_timeout", rdy(x), 1);
  endtask

  task automatic wait_in_wait(input string nm);
    int k = 0;
    while (!(GNT == 2'b01 && !S_HSEL) && k < 30) begin @(negedge HCLK); k++; end
    chk(nm, (GNT == 2'b01 && !S_HSEL), 1);
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_gnt"}, GNT, 2'b00);
    chk({p, "_s_hsel"}, S_HSEL, 0);
    chk({p, "_s_htrans"}, S_HTRANS, 2'b00);
    chk({p, "_s_haddr"}, S_HADDR, 0);
    chk({p, "_rdy0"}, HREADYOUT_0, 1);
    chk({p, "_rdy1"}, HREADYOUT_1, 1);
    chk({p, "_rdata0"}, HRDATA_0, 0);
    chk({p, "_rdata1"}, HRDATA_1, 0);
  endtask

  initial begin
    int lat, k, d0, d1, cyc;
    logic [1:0] gs;
    bit low1;
    int cnt[2];
    bit busy[2];

    HRESET = 1'b1;
    setreq(0, 1'b0, 2'b00, '0, 1'b0);
    setreq(1, 1'b0, 2'b00, '0, 1'b0);
    repeat (2) @(negedge HCLK);
    chk_reset_vals("reset");
    chk_en = 1;
    HRESET = 1'b0;

    // Same-cycle reads: first tie after reset goes to requester 0.
    @(negedge HCLK);
    setreq(0, 1'b1, 2'b10, 24'h04, 1'b0);
    setreq(1, 1'b1, 2'b10, 24'h08, 1'b0);
    d0 = 0; d1 = 0; k = 0;
    while ((d0 == 0 || d1 == 0) && k < 60) begin
      @(negedge HCLK); k++;
      setreq(0, 1'b0, 2'b00, '0, 1'b0);
      setreq(1, 1'b0, 2'b00, '0, 1'b0);
      if (d0 == 0 && HREADYOUT_0) d0 = k;
      if (d1 == 0 && HREADYOUT_1) d1 = k;
    end
    chk("tie_done0", d0, 4);
    chk("tie_done1", d1, 7);
    chk("tie_data0", HRDATA_0, 32'h07060504);
    chk("tie_data1", HRDATA_1, 32'h0b0a0908);

    // Single-requester reads with zero-wait downstream.
    rd(0, 24'h00, lat, gs);
    chk("r0_lat", lat, 4); chk("r0_gnt", gs, 2'b01); chk("r0_data", HRDATA_0, 32'h03020100);
    chk("r0_other_kept", HRDATA_1, 32'h0b0a0908);
    rd(0, 24'h20, lat, gs);
    chk("r20_lat", lat, 4); chk("r20_data", HRDATA_0, 32'h23222120);
    rd(1, 24'h08, lat, gs);
    chk("r1_lat", lat, 4); chk("r1_gnt", gs, 2'b10); chk("r1_data", HRDATA_1, 32'h0b0a0908);
    chk("r1_other_kept", HRDATA_0, 32'h23222120);

    // Continuous back-to-back requests from both sides: grants must alternate.
    glog.delete();
    cnt[0] = 0; cnt[1] = 0; busy[0] = 0; busy[1] = 0; cyc = 0;
    while ((cnt[0] < 6 || cnt[1] < 6 || busy[0] || busy[1]) && cyc < 400) begin
      @(negedge HCLK); cyc++;
      for (int x = 0; x < 2; x++) begin
        if (busy[x] && rdy(x)) begin
          chk($sformatf("stream_data%0d", x), rdat(x), (x == 0) ? 32'h0f0e0d0c : 32'h2f2e2d2c);
          busy[x] = 0;
        end
        if (rdy(x) && cnt[x] < 6) begin
          setreq(x, 1'b1, 2'b10, (x == 0) ? 24'h0C : 24'h2C, 1'b0);
          cnt[x]++; busy[x] = 1;
        end else setreq(x, 1'b0, 2'b00, '0, 1'b0);
      end
    end
    chk("stream_timeout", cyc < 400, 1);
    chk("stream_grants", glog.size(), 12);
    for (int i = 0; i < glog.size(); i++) chk($sformatf("stream_gnt%0d", i), glog[i], i % 2);

    // Write from requester 1 during requester 0's WAIT.
    slv_waits = 3; glog.delete(); low1 = 0;
    @(negedge HCLK);
    setreq(0, 1'b1, 2'b10, 24'h10, 1'b0);
    @(negedge HCLK);
    setreq(0, 1'b0, 2'b00, '0, 1'b0);
    wait_in_wait("wr_reach_wait");
    setreq(1, 1'b1, 2'b10, 24'h30, 1'b1);
    k = 0;
    do begin
      @(negedge HCLK); k++;
      setreq(1, 1'b0, 2'b00, '0, 1'b0);
      if (!HREADYOUT_1) low1 = 1;
    end while (!HREADYOUT_0 && k < 30);
    chk("wr_rdy1_low", low1, 0);
    chk("wr_issues", glog.size(), 1);
    chk("wr_data0", HRDATA_0, 32'h13121110);

    // Reset during WAIT abandons the read.
    @(negedge HCLK);
    setreq(0, 1'b1, 2'b10, 24'h24, 1'b0);
    @(negedge HCLK);
    setreq(0, 1'b0, 2'b00, '0, 1'b0);
    wait_in_wait("rst_reach_wait");
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    chk_reset_vals("midrst");
    glog.delete();
    repeat (6) @(negedge HCLK);
    chk("midrst_no_issue", glog.size(), 0);
    chk("midrst_rdy0", HREADYOUT_0, 1);
    slv_waits = 0;
    rd(0, 24'h24, lat, gs);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_data", HRDATA_0, 32'h27262524);

    repeat (2) @(negedge HCLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/ef_qspi_xip_arb.md
EF_QSPI_XIP_ARB -- requirements
Module: ef_qspi_xip_arb

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset.
REQ-002 Parameter AW, default 24: address width forwarded to the XIP controller.
REQ-003 HCLK  in  1  clock; all state updates on the rising edge.
REQ-004 HRESET  in  1  synchronous active-high reset.
REQ-005 HSEL_x, HTRANS_x[1:0], HADDR_x[AW-1:0], HWRITE_x, HREADY_x  in  (x=0,1)  AHB-Lite requester address-phase inputs.
REQ-006 HREADYOUT_x  out  1  and  HRDATA_x  out  32  (x=0,1)  requester responses.
REQ-007 S_HSEL  out  1,  S_HTRANS  out  2,  S_HADDR  out  AW,  S_HREADY  out  1  drive the shared XIP controller.
REQ-008 S_HREADYOUT  in  1  and  S_HRDATA  in  32  are the shared XIP controller responses.
REQ-009 GNT  out  2  one-hot owner of the downstream port; 2'b00 when idle.

Function
REQ-010 Requester x transfer accepted at edge where HREADY_x & HSEL_x & HTRANS_x[1] = 1.
REQ-011 Accepted read (HWRITE_x=0): set PEND_x, latch HADDR_x; HREADYOUT_x=0 from next cycle.
REQ-012 Accepted write: no downstream access, PEND_x unchanged, HREADYOUT_x stays 1 (zero-wait OKAY; data discarded).
REQ-013 HREADYOUT_x=1 whenever PEND_x=0 and no response is in flight for x.
REQ-014 FSM states IDLE, ISSUE, WAIT.
REQ-015 IDLE: no PEND_x -> stay; otherwise select owner, GNT=owner -> ISSUE next cycle.
REQ-016 Selection: single pending wins; both pending -> requester not granted last (round robin); LAST pointer reset value 1, so requester 0 wins the first tie.
REQ-017 ISSUE: S_HSEL=1, S_HTRANS=2'b10, S_HADDR=latched address of owner; advance to WAIT at edge where S_HREADYOUT=1, else hold.
REQ-018 WAIT: S_HSEL=0, S_HTRANS=2'b00; at edge where S_HREADYOUT=1 -> capture S_HRDATA into HRDATA_owner, clear PEND_owner, LAST=owner, go IDLE.
REQ-019 HREADYOUT_owner SHALL be 1 in the cycle after WAIT completion, with HRDATA_owner valid in that cycle.
REQ-020 Minimum latency: address phase cycle N -> HREADYOUT_x=1 in cycle N+4 with zero-wait downstream (IDLE N+1, ISSUE N+2, WAIT N+3).
REQ-021 S_HREADY SHALL equal S_HREADYOUT combinationally in every state.
REQ-022 Outside ISSUE: S_HSEL=0, S_HTRANS=2'b00, S_HADDR holds last value.
REQ-023 Accepting a new address phase on requester y while another requester is being serviced SHALL set PEND_y without disturbing the current transfer.
REQ-024 Back-to-back: a requester may present its next address phase in the cycle its HREADYOUT_x returns to 1; it is accepted normally.
REQ-025 HRDATA_x holds its last captured value until the next completion for x; HRDATA_x is never changed by the other requester's transfer.
REQ-026 No starvation: with both requesters continuously requesting, grants SHALL alternate 0,1,0,1.

Reset
REQ-027 HRESET=1 at an edge: FSM=IDLE, PEND_0=PEND_1=0, LAST=1, GNT=0, HREADYOUT_0=HREADYOUT_1=1, HRDATA_0=HRDATA_1=0, S_HSEL=0, S_HTRANS=0, S_HADDR=0.
REQ-028 Reset asserted mid-transfer SHALL abandon the transfer; no response is delivered for it after reset.

Verification
REQ-029 Requester 0 only, flash preloaded with byte i at address i: read 0x00 -> HRDATA_0=0x03020100; read 0x20 -> 0x23222120; GNT=2'b01 during the transfer.
REQ-030 Same-cycle reads, requester 0 at 0x04 and requester 1 at 0x08 -> requester 0 completes first with 0x07060504, then requester 1 with 0x0b0a0908.
REQ-031 Six consecutive same-cycle pairs (0x0C/0x2C) -> GNT sequence 01,10,01,10,... and every read returns the correct data (0x0f0e0d0c, 0x2f2e2d2c).
REQ-032 Write from requester 1 while requester 0's read of 0x10 is in WAIT -> requester 1 HREADYOUT stays 1; no S_HSEL pulse for the write; requester 0 receives 0x13121110.
REQ-033 HRESET pulsed during WAIT of a read from 0x24 -> all outputs at their REQ-027 values on the next edge; a subsequent read of 0x24 returns 0x27262524.
REQ-034 Zero-wait downstream model -> HREADYOUT_x high exactly 4 cycles after the address phase (REQ-020); S_HREADY tracks S_HREADYOUT in every cycle.
